// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first,
// one bit per clock, with a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_s;
  logic fa_c;
  logic last;
  logic load;

  // Full-adder cell on the current operand LSBs and the carry flop
  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c = (a_sr[0] & b_sr[0])
         | (b_sr[0] & carry)
         | (a_sr[0] & carry);
  end

  // Next state; start is honoured in IDLE and in DONE (back-to-back)
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        last = (cnt == CW'(WIDTH - 1));
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand/result shifters, carry, counter and the published result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_s, r_sr[WIDTH-1:1]};
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios
// plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       c4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a_in  (a4),
    .b_in  (b4),
    .cin   (c4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic       c,
                         input logic [7:0] es,
                         input logic       ec,
                         input string      tag);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_done_e0"}, 32'(done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
      chk({tag, "_done_run"}, 32'(done), 32'd0);
    end
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    step();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    c4     = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf");
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf_cin");

    // start while running is ignored
    a_in  = 8'h12;
    b_in  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_sum_hold", 32'(sum), 32'hFF);
    repeat (5) step();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum", 32'(sum), 32'h46);
    chk("ign_cout", 32'(cout), 32'd0);
    step();
    chk("ign_no_relaunch", 32'(busy), 32'd0);
    step();
    chk("ign_idle", 32'(busy), 32'd0);

    // reset mid-run aborts
    a_in  = 8'h80;
    b_in  = 8'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

    // back-to-back with start held high
    a_in  = 8'h0F;
    b_in  = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    step();
    a_in = 8'h10;
    b_in = 8'h10;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("b2b_busy1", 32'(busy), 32'd1);
    end
    step();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_busy_gap1", 32'(busy), 32'd0);
    chk("b2b_sum1", 32'(sum), 32'h10);
    step();
    chk("b2b_relaunch", 32'(busy), 32'd1);
    chk("b2b_done_clr", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("b2b_busy2", 32'(busy), 32'd1);
    end
    step();
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_sum2", 32'(sum), 32'h20);
    chk("b2b_cout2", 32'(cout), 32'd0);
    step();
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_done", 32'(done), 32'd0);

    // exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      a4     = i[3:0];
      b4     = i[7:4];
      c4     = i[8];
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      repeat (3) step();
      chk("w4_busy", 32'(busy4), 32'd1);
      step();
      chk("w4_done", 32'(done4), 32'd1);
      chk("w4_result", 32'({cout4, sum4}),
          32'(i[3:0]) + 32'(i[7:4]) + 32'(i[8]));
      step();
      chk("w4_done_width", 32'(done4), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Adds two WIDTH-bit operands by stepping one single-bit full-adder cell (sum = a^b^c, carry = ab|bc|ac) LSB-first, one bit per clock.
- Owns the operand shift registers, the carry flop, the bit counter and a start/busy/done handshake.
- Used where the area of a full ripple adder is not justified and latency of WIDTH cycles is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- start  input   1      request a new addition; sampled on a rising clk edge
- a_in   input   WIDTH  operand A; captured only on the accepted-start edge
- b_in   input   WIDTH  operand B; captured only on the accepted-start edge
- cin    input   1      carry-in; captured only on the accepted-start edge
- busy   output  1      high while an addition is in progress
- done   output  1      one-cycle pulse: result is valid
- sum    output  WIDTH  registered result; holds the last completed value
- cout   output  1      registered carry-out of the MSB; holds the last completed value

Behaviour:
- Single clock domain. Synchronous, active-high reset. All state is registered.
- Reset (rst=1 at an edge) has priority over every other input:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load a_in, b_in into shift registers; carry flop <= cin; counter <= 0; state -> RUN; busy=1 from E0.
  - start=0: remain in IDLE.
- RUN: one bit processed per edge, at E1..E_WIDTH.
  - Full-adder inputs are the LSB of A_sr, the LSB of B_sr and the carry flop.
  - Sum bit shifts into the MSB of an internal result shift register.
  - A_sr and B_sr shift right by 1. Carry flop <= full-adder carry. Counter increments.
  - On the edge that processes bit WIDTH-1 (E_WIDTH): sum <= final result word; cout <= final carry; state -> DONE; busy=0; done=1.
  - start is ignored while in RUN. Operands, result and counter are unaffected.
- DONE (lasts exactly one cycle):
  - Next edge E_WIDTH+1: done=0.
  - If start=1 on that edge, it is accepted exactly as in IDLE (back-to-back): state -> RUN, busy=1.
  - Otherwise state -> IDLE.
- Latency: done is asserted WIDTH edges after the start-accepting edge. Throughput is one addition per WIDTH+1 cycles.
- sum and cout change only on completion edges and on reset. They are not cleared by start and do not expose partial results.
- Result is modulo 2^WIDTH; overflow is reported only via cout.
- Reset mid-RUN: operation aborts, no done pulse, sum/cout forced to 0.
- busy and done are never high in the same cycle.
- Counter width: clog2(WIDTH)+1 bits. No wrap occurs within an operation.

Test Plan (WIDTH=8 unless stated):
- a_in=0x5A, b_in=0x3C, cin=0, start pulsed at E0 -> busy high E0..E7; done high for the single cycle after E8; sum=0x96, cout=0.
- a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34. At E3 hold start=1 with a_in=0xFF, b_in=0xFF -> ignored; done after E8 with sum=0x46, cout=0; no second operation launched.
- Start 0x80+0x80. Assert rst at E4 -> busy=0, done never pulses, sum=0x00, cout=0. Next start of 0x01+0x01 -> sum=0x02.
- Back-to-back: start held high continuously with 0x0F+0x01, then 0x10+0x10 presented -> done pulses after E8 (sum=0x10) and after E17 (sum=0x20); busy low only during the DONE cycles.
- Exhaustive with WIDTH=4: all 512 (a, b, cin) combinations -> {cout, sum} equals a+b+cin for each; done pulse width is always 1 cycle.
